pc_enc_scheduler: RTL and testbench

PC_ENC_SCHEDULER -- requirements
Module: pc_enc_scheduler

---
 rtl/pc_enc_scheduler_pkg.sv | 9 +
 rtl/pc_tag_delay.sv | 24 ++
 rtl/pc_enc_scheduler.sv | 86 ++++++++
 tb/tb_pc_enc_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pc_enc_scheduler_pkg.sv
// pc_enc_scheduler_pkg: shared geometry, pass encoding and FSM states for the product-code scheduler
package pc_enc_scheduler_pkg;
    localparam int LANES = 16;
    localparam int K = 239;
    localparam int N = 256;
    localparam logic ROW_PASS = 1'b0;
    localparam logic COL_PASS = 1'b1;
    typedef enum logic [2:0] {IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, DONE} state_t;
endpackage

// File: rtl/pc_tag_delay.sv
// pc_tag_delay: fixed-latency shift register carrying batch tags alongside the encoder bank
module pc_tag_delay #(
    parameter int ENC_LAT = 2,
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);
    logic [W-1:0] r_pipe [ENC_LAT];

    // shift every cycle so stalls upstream never disturb tags already in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENC_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < ENC_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[ENC_LAT-1];
endmodule

// File: rtl/pc_enc_scheduler.sv
// pc_enc_scheduler: sequences row then column batches of a product-code block through the encoder bank
module pc_enc_scheduler #(
    parameter int LANES = pc_enc_scheduler_pkg::LANES,
    parameter int K = pc_enc_scheduler_pkg::K,
    parameter int N = pc_enc_scheduler_pkg::N,
    parameter int ENC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mem_rdy,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic             rd_pass,
    output logic [7:0]       rd_base,
    output logic [LANES-1:0] rd_mask,
    output logic             wr_en,
    output logic             wr_pass,
    output logic [7:0]       wr_base,
    output logic [LANES-1:0] wr_mask
);
    import pc_enc_scheduler_pkg::*;

    localparam int ROW_BATCHES = (K + LANES - 1) / LANES;
    localparam int COL_BATCHES = N / LANES;
    localparam logic [7:0] ROW_LAST = 8'((ROW_BATCHES - 1) * LANES);
    localparam logic [7:0] COL_LAST = 8'((COL_BATCHES - 1) * LANES);
    localparam int TW = 10 + LANES;

    state_t r_state, w_state_nxt;
    logic [7:0] r_batch, w_batch_nxt;
    logic w_last;
    logic [TW-1:0] w_rd_tag, w_wr_tag;

    // state and batch counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_batch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_batch <= w_batch_nxt;
        end
    end

    // next state; drain states wait for the final tagged write so passes never overlap
    always_comb begin
        w_state_nxt = r_state;
        w_batch_nxt = r_batch;
        rd_en = 1'b0;
        w_last = r_batch == 8'((r_state == COL ? COL_BATCHES : ROW_BATCHES) - 1);
        case (r_state)
            IDLE: w_state_nxt = start ? ROW : IDLE;
            ROW, COL: begin
                rd_en = mem_rdy;
                w_batch_nxt = !mem_rdy ? r_batch : w_last ? 8'd0 : r_batch + 8'd1;
                if (mem_rdy && w_last) w_state_nxt = r_state == ROW ? ROW_DRAIN : COL_DRAIN;
            end
            ROW_DRAIN: if (wr_en && wr_pass == ROW_PASS && wr_base == ROW_LAST) w_state_nxt = COL;
            COL_DRAIN: if (wr_en && wr_pass == COL_PASS && wr_base == COL_LAST) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // read tags; lanes past the last information row are masked off
    always_comb begin
        rd_pass = rd_en && r_state == COL;
        rd_base = rd_en ? 8'(int'(r_batch) * LANES) : 8'd0;
        for (int i = 0; i < LANES; i++)
            rd_mask[i] = rd_en && (int'(r_batch) * LANES + i < (r_state == COL ? N : K));
    end

    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
    assign w_rd_tag = {rd_en, rd_pass, rd_base, rd_mask};
    assign {wr_en, wr_pass, wr_base, wr_mask} = w_wr_tag;

    pc_tag_delay #(.ENC_LAT(ENC_LAT), .W(TW)) u_delay (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_rd_tag),
        .o_data (w_wr_tag)
    );
endmodule

// File: tb/tb_pc_enc_scheduler.sv
// tb_pc_enc_scheduler: directed checks of batch sequencing, stalls, reset abort and start filtering
module tb_pc_enc_scheduler;
    logic clk = 1'b0;
    logic reset, start, mem_rdy;
    logic busy, done, rd_en, rd_pass, wr_en, wr_pass;
    logic [7:0] rd_base, wr_base;
    logic [15:0] rd_mask, wr_mask;
    logic [53:0] all_o;
    int errors = 0;
    int checks = 0;
    logic [25:0] s_rd [64];
    logic [25:0] s_wr [64];
    logic s_done [64];
    logic s_busy [64];

    always #5 clk = ~clk;

    assign all_o = {busy, done, rd_en, rd_pass, rd_base, rd_mask, wr_en, wr_pass, wr_base, wr_mask};

    pc_enc_scheduler #(.ENC_LAT(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mem_rdy (mem_rdy),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_pass (rd_pass),
        .rd_base (rd_base),
        .rd_mask (rd_mask),
        .wr_en   (wr_en),
        .wr_pass (wr_pass),
        .wr_base (wr_base),
        .wr_mask (wr_mask)
    );

    task automatic drive(input int ncyc, input int start_until, input int stall_lo, input int stall_hi);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = c <= start_until;
            mem_rdy = !(c >= stall_lo && c <= stall_hi);
            #1;
            s_rd[c] = {rd_en, rd_pass, rd_base, rd_mask};
            s_wr[c] = {wr_en, wr_pass, wr_base, wr_mask};
            s_done[c] = done;
            s_busy[c] = busy;
        end
    endtask

    function automatic logic [25:0] exp_nom(input int c);
        if (c >= 1 && c <= 15) return {2'b10, 8'(16 * (c - 1)), c == 15 ? 16'h7FFF : 16'hFFFF};
        if (c >= 18 && c <= 33) return {2'b11, 8'(16 * (c - 18)), 16'hFFFF};
        return 26'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (all_o !== 54'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", all_o); end
        reset = 1'b0;
        drive(6, -1, 99, 99);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({s_busy[c], s_rd[c][25], s_wr[c][25]} !== 3'b000)
                begin errors++; $display("FAIL idle_no_start c=%0d got=%b exp=000", c, {s_busy[c], s_rd[c][25], s_wr[c][25]}); end
        end
    endtask

    task automatic test_nominal();
        drive(40, 0, 99, 99);
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (s_rd[c] !== exp_nom(c)) begin errors++; $display("FAIL nominal_rd c=%0d got=%h exp=%h", c, s_rd[c], exp_nom(c)); end
            checks++;
            if (s_wr[c] !== exp_nom(c - 2)) begin errors++; $display("FAIL nominal_wr c=%0d got=%h exp=%h", c, s_wr[c], exp_nom(c - 2)); end
            checks++;
            if (s_done[c] !== (c == 36)) begin errors++; $display("FAIL nominal_done c=%0d got=%b exp=%b", c, s_done[c], c == 36); end
            checks++;
            if (s_busy[c] !== (c >= 1 && c <= 36)) begin errors++; $display("FAIL nominal_busy c=%0d got=%b exp=%b", c, s_busy[c], c >= 1 && c <= 36); end
        end
        checks++;
        if (s_rd[15] !== {2'b10, 8'd224, 16'h7FFF}) begin errors++; $display("FAIL last_row_mask got=%h exp=%h", s_rd[15], {2'b10, 8'd224, 16'h7FFF}); end
    endtask

    task automatic test_stall();
        logic [25:0] er [64];
        int k = 0;
        int nrd = 0;
        int nwr = 0;
        int nd = 0;
        logic en;
        drive(45, 0, 2, 3);
        for (int c = 0; c < 45; c++) begin
            en = (c == 1) || (c >= 4 && c <= 17) || (c >= 20 && c <= 35);
            er[c] = en ? {1'b1, k >= 15, 8'(16 * (k >= 15 ? k - 15 : k)), k == 14 ? 16'h7FFF : 16'hFFFF} : 26'd0;
            if (en) k++;
            nrd += int'(s_rd[c][25]);
            nwr += int'(s_wr[c][25]);
            nd += int'(s_done[c]);
            checks++;
            if (s_rd[c] !== er[c]) begin errors++; $display("FAIL stall_rd c=%0d got=%h exp=%h", c, s_rd[c], er[c]); end
            checks++;
            if (s_wr[c] !== (c >= 2 ? er[c-2] : 26'd0))
                begin errors++; $display("FAIL stall_wr c=%0d got=%h exp=%h", c, s_wr[c], c >= 2 ? er[c-2] : 26'd0); end
            checks++;
            if (s_done[c] !== (c == 38)) begin errors++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, s_done[c], c == 38); end
        end
        checks++;
        if (nrd != 31 || nwr != 31 || nd != 1)
            begin errors++; $display("FAIL stall_totals got rd=%0d wr=%0d done=%0d exp rd=31 wr=31 done=1", nrd, nwr, nd); end
    endtask

    task automatic test_reset_mid();
        drive(20, 0, 99, 99);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (all_o !== 54'd0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", all_o); end
        @(negedge clk);
        reset = 1'b0;
        drive(10, -1, 99, 99);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({s_busy[c], s_wr[c][25]} !== 2'b00)
                begin errors++; $display("FAIL midreset_quiet c=%0d got=%b exp=00", c, {s_busy[c], s_wr[c][25]}); end
        end
        test_nominal();
    endtask

    task automatic test_start_held();
        int nd = 0;
        drive(45, 36, 99, 99);
        for (int c = 0; c < 45; c++) begin
            nd += int'(s_done[c]);
            checks++;
            if (s_done[c] !== (c == 36)) begin errors++; $display("FAIL held_done c=%0d got=%b exp=%b", c, s_done[c], c == 36); end
            checks++;
            if (s_busy[c] !== (c >= 1 && c <= 36)) begin errors++; $display("FAIL held_busy c=%0d got=%b exp=%b", c, s_busy[c], c >= 1 && c <= 36); end
            checks++;
            if (s_rd[c] !== exp_nom(c)) begin errors++; $display("FAIL held_rd c=%0d got=%h exp=%h", c, s_rd[c], exp_nom(c)); end
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL held_done_count got=%0d exp=1", nd); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_reset_mid();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
